pwm_multi: RTL and testbench

Multi-channel PWM generator driving the drone's motor ESC inputs; successor to the single-channel `pwm` block. One shared period counter with programmable prescaler feeds `NUM_CH` comparators. Per-channel duty values are double-buffered so updates take effect only at a period boundary, which keeps the outputs glitch-free. A communication watchdog forces all motors off if the flight controller stops writing duties.

---
 rtl/pwm_multi.sv | 80 ++++++++
 tb/tb_pwm_multi.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with shared prescaled period counter, double-buffered duties
// and a communication watchdog that forces all outputs off when duty writes stop.
module pwm_multi #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 7,
  parameter int PRESCALE_W   = 8,
  parameter int WDOG_PERIODS = 16,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WD_W        = $clog2(WDOG_PERIODS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  wr_valid,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic [CNT_W-1:0]      wr_duty,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic                  period_start,
  output logic                  failsafe
);
  logic [PRESCALE_W-1:0] ps_q, ps_d, ps_act_q, ps_act_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      pending_q [NUM_CH];
  logic [CNT_W-1:0]      pending_d [NUM_CH];
  logic [CNT_W-1:0]      active_q [NUM_CH];
  logic [CNT_W-1:0]      active_d [NUM_CH];
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [NUM_CH-1:0]     pwm_q, pwm_d;
  logic                  start_q, start_d, failsafe_q, failsafe_d, en_q, en_d;
  logic                  tick, bnd, wr_hit, expire;
  // The output is computed from next-state cnt/active so that period_start and the
  // first pwm_out cycle of the new period line up.
  always_comb begin
    tick       = enable && (ps_q == ps_act_q);
    bnd        = enable && (!en_q || (tick && (&cnt_q)));
    wr_hit     = wr_valid && (32'(wr_ch) < NUM_CH);
    expire     = bnd && !wr_hit && (wd_q == WD_W'(WDOG_PERIODS - 1));
    ps_d       = (!enable || bnd || tick) ? '0 : ps_q + 1'b1;
    cnt_d      = (!enable || bnd) ? '0 : cnt_q + CNT_W'(tick);
    ps_act_d   = bnd ? prescale : ps_act_q;
    wd_d       = wr_hit ? '0 : (bnd && wd_q != WD_W'(WDOG_PERIODS)) ? wd_q + 1'b1 : wd_q;
    failsafe_d = wr_hit ? 1'b0 : (failsafe_q || expire);
    start_d    = bnd;
    en_d       = enable;
    for (int c = 0; c < NUM_CH; c++) begin
      pending_d[c] = (wr_hit && wr_ch == CH_W'(c)) ? wr_duty : expire ? '0 : pending_q[c];
      active_d[c]  = !bnd ? active_q[c] : (wr_hit && wr_ch == CH_W'(c)) ? wr_duty : pending_q[c];
      pwm_d[c]     = enable && !failsafe_q && (cnt_d < active_d[c]);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q       <= '0;
      ps_act_q   <= '0;
      cnt_q      <= '0;
      pending_q  <= '{default: '0};
      active_q   <= '{default: '0};
      wd_q       <= '0;
      pwm_q      <= '0;
      start_q    <= 1'b0;
      failsafe_q <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      ps_q       <= ps_d;
      ps_act_q   <= ps_act_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      active_q   <= active_d;
      wd_q       <= wd_d;
      pwm_q      <= pwm_d;
      start_q    <= start_d;
      failsafe_q <= failsafe_d;
      en_q       <= en_d;
    end
  end
  assign pwm_out      = pwm_q;
  assign period_start = start_q;
  assign failsafe     = failsafe_q;
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: table-driven period measurements, directed corner sequences and a
// randomized phase, all cross-checked every cycle against an elapsed-time reference model.
module tb_pwm_multi;
  localparam int N = 4, W = 7, PW = 8, WD = 4, P = 1 << W;
  logic clk = 0, reset = 1, enable = 0, wr_valid = 0;
  logic [PW-1:0] prescale = '0;
  logic [1:0] wr_ch = '0;
  logic [W-1:0] wr_duty = '0;
  logic [N-1:0] pwm_out;
  logic period_start, failsafe;
  int tests = 0, fails = 0;
  bit chk_on = 0;
  pwm_multi #(.NUM_CH(N), .CNT_W(W), .PRESCALE_W(PW), .WDOG_PERIODS(WD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .prescale(prescale), .wr_valid(wr_valid),
    .wr_ch(wr_ch), .wr_duty(wr_duty), .pwm_out(pwm_out), .period_start(period_start),
    .failsafe(failsafe));
  always #5 clk = ~clk;
  // Reference model: position in the period is elapsed clocks / clocks-per-tick.
  int el = 0, per = 1, wdc = 0;
  int pend [N];
  int act [N];
  bit en_prev = 0, fs = 0, fs_old, hit, bnd, e_ps = 0, e_fs = 0;
  logic [N-1:0] e_pwm = '0;
  always @(posedge clk) begin
    if (reset) begin
      el = 0; per = 1; wdc = 0; en_prev = 0; fs = 0; e_pwm = '0; e_ps = 0; e_fs = 0;
      for (int c = 0; c < N; c++) begin pend[c] = 0; act[c] = 0; end
    end else begin
      hit = wr_valid && (int'(wr_ch) < N);
      bnd = enable && (!en_prev || el == P * per - 1);
      fs_old = fs;
      if (bnd) for (int c = 0; c < N; c++) act[c] = (hit && int'(wr_ch) == c) ? int'(wr_duty) : pend[c];
      if (hit) begin
        pend[wr_ch] = int'(wr_duty); wdc = 0; fs = 0;
      end else if (bnd && wdc < WD) begin
        wdc++;
        if (wdc == WD) begin
          fs = 1;
          for (int c = 0; c < N; c++) pend[c] = 0;
        end
      end
      if (!enable) el = 0;
      else if (bnd) begin el = 0; per = int'(prescale) + 1; end
      else el++;
      en_prev = enable; e_ps = bnd; e_fs = fs;
      for (int c = 0; c < N; c++) e_pwm[c] = enable && !fs_old && (el / per < act[c]);
    end
  end
  task automatic tick();
    @(negedge clk);
    if (chk_on) begin
      tests++;
      if ({pwm_out, period_start, failsafe} !== {e_pwm, e_ps, e_fs}) begin
        fails++;
        $display("FAIL model t=%0t: pwm=%b ps=%b fs=%b expected pwm=%b ps=%b fs=%b",
                 $time, pwm_out, period_start, failsafe, e_pwm, e_ps, e_fs);
      end
    end
  endtask
  task automatic check(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic wr(input int ch, input int d);
    wr_valid = 1; wr_ch = 2'(ch); wr_duty = W'(d);
    tick();
    wr_valid = 0;
  endtask
  task automatic wait_start();
    int n = 0;
    do begin tick(); n++; end while (!period_start && n < 3000);
    if (n >= 3000) check("wait_start", int'(period_start), 1);
  endtask
  // Starts on a period_start cycle and runs to the next one, optionally writing at index wr_at.
  task automatic count_period(input int ch, input int wr_at, input int wr_d,
                              output int hi, output int len, output int oth, output int edges);
    bit prev = 0;
    hi = 0; len = 0; oth = 0; edges = 0;
    do begin
      if (pwm_out[ch] && !prev) edges++;
      prev = pwm_out[ch];
      hi += int'(pwm_out[ch]);
      oth += $countones(pwm_out) - int'(pwm_out[ch]);
      if (len == wr_at) begin wr_valid = 1; wr_ch = 2'(ch); wr_duty = W'(wr_d); end
      len++;
      tick();
      wr_valid = 0;
    end while (!period_start && len < 5000);
  endtask
  task automatic measure(input int ch, output int hi, output int len, output int oth, output int edges);
    wait_start();
    count_period(ch, -1, 0, hi, len, oth, edges);
  endtask
  typedef struct {int ch; int duty; int presc; int exp_hi; int exp_len;} vec_t;
  vec_t vt [6];
  int hi, len, oth, edges;
  initial begin
    vt = '{'{0, 0, 0, 0, 128}, '{0, 127, 0, 127, 128}, '{1, 1, 0, 1, 128},
           '{2, 10, 3, 40, 512}, '{3, 64, 1, 128, 256}, '{1, 100, 2, 300, 384}};
    repeat (3) tick();
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_ps", int'(period_start), 0);
    check("reset_fs", int'(failsafe), 0);
    reset = 0; chk_on = 1;
    repeat (3) tick();
    enable = 1;
    foreach (vt[i]) begin
      prescale = PW'(vt[i].presc);
      for (int c = 0; c < N; c++) wr(c, (c == vt[i].ch) ? vt[i].duty : 0);
      measure(vt[i].ch, hi, len, oth, edges);
      check($sformatf("vec%0d_high", i), hi, vt[i].exp_hi);
      check($sformatf("vec%0d_len", i), len, vt[i].exp_len);
      check($sformatf("vec%0d_other", i), oth, 0);
      check($sformatf("vec%0d_edges", i), edges, (vt[i].exp_hi > 0) ? 1 : 0);
    end
    prescale = 0;
    for (int c = 0; c < N; c++) wr(c, 0);
    for (int d = 0; d < P; d++) begin
      wr(0, d);
      measure(0, hi, len, oth, edges);
      check($sformatf("sweep%0d_high", d), hi, d);
      check($sformatf("sweep%0d_len", d), len, P);
      check($sformatf("sweep%0d_other", d), oth, 0);
    end
    wr(0, 0); wr(1, 20);
    wait_start();
    count_period(1, 40, 100, hi, len, oth, edges);
    check("mid_cur_high", hi, 20);
    check("mid_cur_edges", edges, 1);
    count_period(1, -1, 0, hi, len, oth, edges);
    check("mid_next_high", hi, 100);
    check("mid_next_edges", edges, 1);
    check("mid_next_len", len, P);
    wr(1, 0); wr(2, 10); prescale = 3;
    measure(2, hi, len, oth, edges);
    check("ps3_high", hi, 40);
    check("ps3_len", len, 512);
    prescale = 0;
    count_period(2, -1, 0, hi, len, oth, edges);
    check("ps_chg_cur_high", hi, 40);
    check("ps_chg_cur_len", len, 512);
    count_period(2, -1, 0, hi, len, oth, edges);
    check("ps_chg_next_high", hi, 10);
    check("ps_chg_next_len", len, P);
    wr(2, 0);
    wait_start();
    count_period(3, P - 1, 90, hi, len, oth, edges);
    check("bwr_prev_high", hi, 0);
    count_period(3, -1, 0, hi, len, oth, edges);
    check("bwr_high", hi, 90);
    for (int c = 0; c < N; c++) wr(c, 64);
    for (int k = 1; k <= WD; k++) begin
      wait_start();
      check($sformatf("wd_fs_b%0d", k), int'(failsafe), (k == WD) ? 1 : 0);
    end
    tick();
    check("wd_gate", int'(pwm_out), 0);
    wait_start();
    check("wd_fs_hold", int'(failsafe), 1);
    wr(2, 50);
    check("wd_clear", int'(failsafe), 0);
    measure(2, hi, len, oth, edges);
    check("wd_ch2_high", hi, 50);
    check("wd_other", oth, 0);
    wr(2, 0); wr(0, 100);
    wait_start();
    repeat (30) tick();
    reset = 1;
    tick();
    reset = 0;
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ps_low", int'(period_start), 0);
    tick();
    check("rst_ps_pulse", int'(period_start), 1);
    count_period(0, -1, 0, hi, len, oth, edges);
    check("rst_high", hi, 0);
    check("rst_len", len, P);
    for (int i = 0; i < 14000; i++) begin
      if (enable ? ($urandom_range(0, 799) == 0) : ($urandom_range(0, 19) == 0)) enable = !enable;
      reset = ($urandom_range(0, 4999) == 0);
      wr_valid = ($urandom_range(0, (i < 7000) ? 100 : 3000) == 0);
      wr_ch = 2'($urandom_range(0, 3));
      wr_duty = W'($urandom);
      prescale = PW'($urandom_range(0, 2));
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
